// File: rtl/ysyx_22041752_rf_wport_arb_pkg.sv
// Shared widths and state encodings for the regfile write-port arbiter.
package ysyx_22041752_rf_wport_arb_pkg;

    localparam int unsigned RF_ADDR_WD_DEF   = 5;
    localparam int unsigned RF_DATA_WD_DEF   = 64;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    // Bus widths at the default geometry: {we,waddr,wdata} and {valid,data,rd}
    localparam int unsigned WS_TO_RF_BUS_WD = 1 + RF_ADDR_WD_DEF + RF_DATA_WD_DEF;
    localparam int unsigned FORWARD_BUS_WD  = 1 + RF_DATA_WD_DEF + RF_ADDR_WD_DEF;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_HOLD = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ysyx_22041752_scoreboard.sv
// Per-register pending-MDU-destination scoreboard with hazard read ports and
// sticky protocol-error detection.
module ysyx_22041752_scoreboard
    import ysyx_22041752_rf_wport_arb_pkg::*;
#(
    parameter int unsigned RF_ADDR_WD = RF_ADDR_WD_DEF,
    parameter int unsigned NREGS      = 1 << RF_ADDR_WD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_valid,
    input  logic [RF_ADDR_WD-1:0] set_rd,
    input  logic                  clr_valid,
    input  logic [RF_ADDR_WD-1:0] clr_rd,
    input  logic                  ws_we,
    input  logic [RF_ADDR_WD-1:0] ws_rd,
    input  logic [RF_ADDR_WD-1:0] rs1_addr,
    input  logic [RF_ADDR_WD-1:0] rs2_addr,
    output logic [NREGS-1:0]      busy,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  err
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic             err_q, err_d;
    logic             set_eff, clr_eff;
    logic             waw_err, wb_err, commit_err;

    assign set_eff = set_valid && (set_rd != '0);
    assign clr_eff = clr_valid && (clr_rd != '0);

    // Next busy vector and error detection; a same-cycle set wins over clear
    always_comb begin
        busy_d = busy_q;
        if (clr_eff) busy_d[clr_rd] = 1'b0;
        if (set_eff) busy_d[set_rd] = 1'b1;

        // Reallocating a register whose result retires this very cycle is not a WAW
        waw_err    = set_eff && busy_q[set_rd] && !(clr_eff && (clr_rd == set_rd));
        wb_err     = ws_we && busy_q[ws_rd];
        commit_err = clr_eff && !busy_q[clr_rd];
        err_d      = err_q || waw_err || wb_err || commit_err;
    end

    // Scoreboard state and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy     = busy_q;
    assign err      = err_q;
    assign rs1_busy = (rs1_addr != '0) && busy_q[rs1_addr];
    assign rs2_busy = (rs2_addr != '0) && busy_q[rs2_addr];

endmodule

// File: rtl/ysyx_22041752_rf_wport_arb.sv
// Regfile write-port arbiter: WB always wins, MDU takes idle slots, and a
// starvation FSM asks ID for a bubble when the MDU waits too long.
module ysyx_22041752_rf_wport_arb
    import ysyx_22041752_rf_wport_arb_pkg::*;
#(
    parameter int unsigned RF_ADDR_WD   = RF_ADDR_WD_DEF,
    parameter int unsigned RF_DATA_WD   = RF_DATA_WD_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [RF_ADDR_WD+RF_DATA_WD:0]       ws_to_rf_bus,
    input  logic                                 mdu_wb_valid,
    output logic                                 mdu_wb_ready,
    input  logic [RF_ADDR_WD-1:0]                mdu_wb_rd,
    input  logic [RF_DATA_WD-1:0]                mdu_wb_data,
    input  logic                                 alloc_valid,
    input  logic [RF_ADDR_WD-1:0]                alloc_rd,
    input  logic [RF_ADDR_WD-1:0]                rs1_addr,
    input  logic [RF_ADDR_WD-1:0]                rs2_addr,
    output logic                                 rs1_busy,
    output logic                                 rs2_busy,
    output logic [(1<<RF_ADDR_WD)-1:0]           sb_busy,
    output logic                                 hold_req,
    output logic [RF_ADDR_WD+RF_DATA_WD:0]       rf_bus,
    output logic [RF_DATA_WD+RF_ADDR_WD:0]       mdu_forward_bus,
    output logic                                 sb_err
);

    localparam int unsigned CntWd = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntWd-1:0] Limit = CntWd'(STARVE_LIMIT);

    logic                  ws_we;
    logic [RF_ADDR_WD-1:0] ws_waddr;
    logic [RF_DATA_WD-1:0] ws_wdata;
    logic                  ws_we_eff;
    logic                  commit;

    arb_state_e       state_q, state_d;
    logic [CntWd-1:0] cnt_q, cnt_d;
    logic             hold_q;

    assign {ws_we, ws_waddr, ws_wdata} = ws_to_rf_bus;

    // Writes to x0 never claim the port
    assign ws_we_eff    = ws_we && (ws_waddr != '0);
    assign mdu_wb_ready = !ws_we_eff;
    assign commit       = mdu_wb_valid && mdu_wb_ready;

    // Write-port mux: WB first, MDU in otherwise idle slots
    always_comb begin
        rf_bus = '0;
        if (ws_we_eff) begin
            rf_bus = {1'b1, ws_waddr, ws_wdata};
        end else if (commit) begin
            rf_bus = {(mdu_wb_rd != '0), mdu_wb_rd, mdu_wb_data};
        end
    end

    assign mdu_forward_bus = {commit && (mdu_wb_rd != '0), mdu_wb_data, mdu_wb_rd};

    // Starvation FSM next state; wait count saturates at the limit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (mdu_wb_valid && !mdu_wb_ready) begin
                    cnt_d   = CntWd'(1);
                    state_d = (cnt_d >= Limit) ? ARB_HOLD : ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                // A dropped valid without commit is illegal; recover to idle
                if (commit || !mdu_wb_valid) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = (cnt_q >= Limit) ? Limit : cnt_q + CntWd'(1);
                    state_d = (cnt_d >= Limit) ? ARB_HOLD : ARB_WAIT;
                end
            end
            ARB_HOLD: begin
                if (commit || !mdu_wb_valid) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, wait counter and registered hold request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= (state_d == ARB_HOLD);
        end
    end

    assign hold_req = hold_q;

    ysyx_22041752_scoreboard #(
        .RF_ADDR_WD (RF_ADDR_WD)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_valid (alloc_valid),
        .set_rd    (alloc_rd),
        .clr_valid (commit),
        .clr_rd    (mdu_wb_rd),
        .ws_we     (ws_we_eff),
        .ws_rd     (ws_waddr),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .busy      (sb_busy),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .err       (sb_err)
    );

endmodule

// File: tb/tb_ysyx_22041752_rf_wport_arb.sv
// Directed bench for the regfile write-port arbiter.
module tb_ysyx_22041752_rf_wport_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [69:0] ws_to_rf_bus;
    logic        mdu_wb_valid;
    logic        mdu_wb_ready;
    logic [4:0]  mdu_wb_rd;
    logic [63:0] mdu_wb_data;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [31:0] sb_busy;
    logic        hold_req;
    logic [69:0] rf_bus;
    logic [69:0] mdu_forward_bus;
    logic        sb_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_22041752_rf_wport_arb dut (
        .clk             (clk),
        .reset           (reset),
        .ws_to_rf_bus    (ws_to_rf_bus),
        .mdu_wb_valid    (mdu_wb_valid),
        .mdu_wb_ready    (mdu_wb_ready),
        .mdu_wb_rd       (mdu_wb_rd),
        .mdu_wb_data     (mdu_wb_data),
        .alloc_valid     (alloc_valid),
        .alloc_rd        (alloc_rd),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .sb_busy         (sb_busy),
        .hold_req        (hold_req),
        .rf_bus          (rf_bus),
        .mdu_forward_bus (mdu_forward_bus),
        .sb_err          (sb_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ws_to_rf_bus = '0;
        mdu_wb_valid = 1'b0;
        mdu_wb_rd    = '0;
        mdu_wb_data  = '0;
        alloc_valid  = 1'b0;
        alloc_rd     = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rs1_addr = '0;
        rs2_addr = '0;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (sb_busy !== 32'h0) begin
            failures++; $display("FAIL reset_busy got=%h exp=0", sb_busy);
        end
        checks++;
        if (hold_req !== 1'b0 || sb_err !== 1'b0) begin
            failures++; $display("FAIL reset_flags got hold=%b err=%b exp=0,0", hold_req, sb_err);
        end
        checks++;
        if (rf_bus[69] !== 1'b0 || mdu_wb_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_port got we=%b ready=%b exp=0,1", rf_bus[69], mdu_wb_ready);
        end
    endtask

    task automatic test_wb_write();
        ws_to_rf_bus = {1'b1, 5'd5, 64'h11};
        #1;
        checks++;
        if (rf_bus !== {1'b1, 5'd5, 64'h11}) begin
            failures++; $display("FAIL wb_bus got=%h exp=%h", rf_bus, {1'b1, 5'd5, 64'h11});
        end
        checks++;
        if (mdu_wb_ready !== 1'b0) begin
            failures++; $display("FAIL wb_ready got=%b exp=0", mdu_wb_ready);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_mdu_commit();
        alloc_valid = 1'b1;
        alloc_rd    = 5'd7;
        tick();
        alloc_valid = 1'b0;
        rs1_addr    = 5'd7;
        rs2_addr    = 5'd0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++;
            if (sb_busy[7] !== 1'b1 || rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
                failures++;
                $display("FAIL busy7_t%0d got busy=%b rs1=%b rs2=%b exp=1,1,0",
                         k, sb_busy[7], rs1_busy, rs2_busy);
            end
            if (k < 3) tick();
        end
        mdu_wb_valid = 1'b1;
        mdu_wb_rd    = 5'd7;
        mdu_wb_data  = 64'hAB;
        #1;
        checks++;
        if (mdu_wb_ready !== 1'b1 || rf_bus !== {1'b1, 5'd7, 64'hAB}) begin
            failures++;
            $display("FAIL mdu_commit got ready=%b bus=%h exp=1,%h",
                     mdu_wb_ready, rf_bus, {1'b1, 5'd7, 64'hAB});
        end
        checks++;
        if (mdu_forward_bus !== {1'b1, 64'hAB, 5'd7}) begin
            failures++;
            $display("FAIL mdu_fwd got=%h exp=%h", mdu_forward_bus, {1'b1, 64'hAB, 5'd7});
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (sb_busy[7] !== 1'b0 || rs1_busy !== 1'b0 || sb_err !== 1'b0) begin
            failures++;
            $display("FAIL busy7_clear got busy=%b rs1=%b err=%b exp=0,0,0",
                     sb_busy[7], rs1_busy, sb_err);
        end
    endtask

    task automatic test_starve();
        alloc_valid = 1'b1;
        alloc_rd    = 5'd3;
        tick();
        alloc_valid  = 1'b0;
        mdu_wb_valid = 1'b1;
        mdu_wb_rd    = 5'd3;
        mdu_wb_data  = 64'h33;
        for (int k = 0; k < 4; k++) begin
            ws_to_rf_bus = {1'b1, 5'd10, 64'(k + 100)};
            #1;
            checks++;
            if (mdu_wb_ready !== 1'b0 || hold_req !== 1'b0) begin
                failures++;
                $display("FAIL starve_wait%0d got ready=%b hold=%b exp=0,0",
                         k, mdu_wb_ready, hold_req);
            end
            tick();
        end
        checks++;
        if (hold_req !== 1'b1) begin
            failures++; $display("FAIL starve_hold got=%b exp=1", hold_req);
        end
        ws_to_rf_bus = '0;
        #1;
        checks++;
        if (mdu_wb_ready !== 1'b1 || rf_bus !== {1'b1, 5'd3, 64'h33}) begin
            failures++;
            $display("FAIL starve_commit got ready=%b bus=%h exp=1,%h",
                     mdu_wb_ready, rf_bus, {1'b1, 5'd3, 64'h33});
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (hold_req !== 1'b0 || sb_busy[3] !== 1'b0 || sb_err !== 1'b0) begin
            failures++;
            $display("FAIL starve_release got hold=%b busy3=%b err=%b exp=0,0,0",
                     hold_req, sb_busy[3], sb_err);
        end
    endtask

    task automatic test_set_clear_same();
        alloc_valid = 1'b1;
        alloc_rd    = 5'd9;
        tick();
        mdu_wb_valid = 1'b1;
        mdu_wb_rd    = 5'd9;
        mdu_wb_data  = 64'h99;
        tick();
        alloc_valid = 1'b0;
        checks++;
        if (sb_busy[9] !== 1'b1 || sb_err !== 1'b0) begin
            failures++;
            $display("FAIL setclr_same got busy9=%b err=%b exp=1,0", sb_busy[9], sb_err);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (sb_busy[9] !== 1'b0 || sb_err !== 1'b0) begin
            failures++;
            $display("FAIL setclr_retire got busy9=%b err=%b exp=0,0", sb_busy[9], sb_err);
        end
    endtask

    task automatic test_rd0();
        mdu_wb_valid = 1'b1;
        mdu_wb_rd    = 5'd0;
        mdu_wb_data  = 64'h55;
        #1;
        checks++;
        if (mdu_wb_ready !== 1'b1 || rf_bus[69] !== 1'b0 || mdu_forward_bus[69] !== 1'b0) begin
            failures++;
            $display("FAIL rd0_commit got ready=%b we=%b fwd=%b exp=1,0,0",
                     mdu_wb_ready, rf_bus[69], mdu_forward_bus[69]);
        end
        tick();
        idle_inputs();
        checks++;
        if (sb_err !== 1'b0 || sb_busy !== 32'h0) begin
            failures++; $display("FAIL rd0_err got err=%b busy=%h exp=0,0", sb_err, sb_busy);
        end
    endtask

    task automatic test_waw();
        alloc_valid = 1'b1;
        alloc_rd    = 5'd4;
        tick();
        checks++;
        if (sb_err !== 1'b0) begin
            failures++; $display("FAIL waw_first got=%b exp=0", sb_err);
        end
        tick();
        alloc_valid = 1'b0;
        checks++;
        if (sb_err !== 1'b1) begin
            failures++; $display("FAIL waw_err got=%b exp=1", sb_err);
        end
        tick();
        tick();
        checks++;
        if (sb_err !== 1'b1 || sb_busy[4] !== 1'b1) begin
            failures++;
            $display("FAIL waw_sticky got err=%b busy4=%b exp=1,1", sb_err, sb_busy[4]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (sb_err !== 1'b0 || sb_busy !== 32'h0) begin
            failures++;
            $display("FAIL waw_reset got err=%b busy=%h exp=0,0", sb_err, sb_busy);
        end
    endtask

    initial begin
        test_reset();
        test_wb_write();
        test_mdu_commit();
        test_starve();
        test_set_clear_same();
        test_rd0();
        test_waw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
